// File: rtl/render_scheduler.sv
// render_scheduler: sequences one solver-bank render per view request and
// walks a raster scan-out counter over the bank's interleaved storage.
module render_scheduler #(
    parameter int NUM_SOLVERS  = 1,
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_view_valid,
    output logic               o_view_ready,
    input  logic signed [26:0] i_view_min_x,
    input  logic signed [26:0] i_view_min_y,
    input  logic signed [26:0] i_view_dx,
    input  logic signed [26:0] i_view_dy,
    output logic signed [26:0] o_min_x,
    output logic signed [26:0] o_min_y,
    output logic signed [26:0] o_max_x,
    output logic signed [26:0] o_max_y,
    output logic signed [26:0] o_dx,
    output logic signed [26:0] o_dy,
    output logic               o_solver_reset,
    input  logic               i_solver_done,
    input  logic               i_scan_sof,
    input  logic               i_scan_advance,
    output logic [5:0]         o_rd_solver_id,
    output logic [18:0]        o_rd_addr,
    input  logic signed [3:0]  i_rd_data,
    output logic signed [3:0]  o_pix_data,
    output logic               o_busy,
    output logic               o_frame_valid,
    output logic [15:0]        o_frame_count
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_RUN} state_t;

    localparam logic [18:0] LAST_PIX = 19'(WIDTH * HEIGHT - 1);
    localparam logic [5:0]  LAST_ID  = 6'(NUM_SOLVERS - 1);
    localparam logic [15:0] LAST_CLR = 16'(CLEAR_CYCLES - 1);

    state_t             r_state, w_next;
    logic [15:0]        r_clr_cnt;
    logic signed [26:0] r_min_x, r_min_y, r_max_x, r_max_y, r_dx, r_dy;
    logic               r_frame_valid;
    logic [15:0]        r_frame_count;
    logic [5:0]         r_id;
    logic [18:0]        r_addr, r_pix;
    logic               w_accept, w_done;
    logic signed [26:0] w_span_x, w_span_y;

    assign o_view_ready   = (r_state == S_IDLE) || (r_state == S_RUN);
    assign o_busy         = r_state != S_IDLE;
    assign o_solver_reset = !((r_state == S_SETTLE) || (r_state == S_RUN));
    assign w_accept       = o_view_ready && i_view_valid;
    // an accept in RUN beats a coincident done
    assign w_done         = (r_state == S_RUN) && i_solver_done && !i_view_valid;
    assign w_span_x       = r_dx * $signed(27'(WIDTH - 1));
    assign w_span_y       = r_dy * $signed(27'(HEIGHT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_view_valid ? S_LOAD : S_IDLE;
            S_LOAD:   w_next = S_CLEAR;
            S_CLEAR:  w_next = (r_clr_cnt == LAST_CLR) ? S_SETTLE : S_CLEAR;
            S_SETTLE: w_next = S_RUN;
            S_RUN:    w_next = i_view_valid ? S_LOAD : (i_solver_done ? S_IDLE : S_RUN);
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + 16'd1 : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_min_x       <= '0;
            r_min_y       <= '0;
            r_max_x       <= '0;
            r_max_y       <= '0;
            r_dx          <= '0;
            r_dy          <= '0;
            r_frame_valid <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_accept) begin
                r_min_x       <= i_view_min_x;
                r_min_y       <= i_view_min_y;
                r_dx          <= i_view_dx;
                r_dy          <= i_view_dy;
                r_frame_valid <= 1'b0;
            end else if (w_done) begin
                r_frame_valid <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (r_state == S_LOAD) begin
                r_max_x <= r_min_x + w_span_x;
                r_max_y <= r_min_y + w_span_y;
            end
        end
    end

    // pixel p maps to solver p mod N, address p / N, tracked incrementally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id   <= '0;
            r_addr <= '0;
            r_pix  <= '0;
        end else if (i_scan_sof || (i_scan_advance && r_pix == LAST_PIX)) begin
            r_id   <= '0;
            r_addr <= '0;
            r_pix  <= '0;
        end else if (i_scan_advance) begin
            r_pix  <= r_pix + 19'd1;
            r_id   <= (r_id == LAST_ID) ? '0 : r_id + 6'd1;
            r_addr <= (r_id == LAST_ID) ? r_addr + 19'd1 : r_addr;
        end
    end

    assign o_min_x        = r_min_x;
    assign o_min_y        = r_min_y;
    assign o_max_x        = r_max_x;
    assign o_max_y        = r_max_y;
    assign o_dx           = r_dx;
    assign o_dy           = r_dy;
    assign o_frame_valid  = r_frame_valid;
    assign o_frame_count  = r_frame_count;
    assign o_rd_solver_id = r_id;
    assign o_rd_addr      = r_addr;
    assign o_pix_data     = r_frame_valid ? i_rd_data : 4'sd0;
endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: directed vectors for the render FSM and scan-out
// counters, using a 3-solver bank and a shortened 640x8 frame.
module tb_render_scheduler;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               view_valid = 1'b0;
    logic               view_ready;
    logic signed [26:0] view_min_x = '0, view_min_y = '0, view_dx = '0, view_dy = '0;
    logic signed [26:0] min_x, min_y, max_x, max_y, dx, dy;
    logic               solver_reset;
    logic               solver_done = 1'b0;
    logic               scan_sof = 1'b0, scan_advance = 1'b0;
    logic [5:0]         rd_solver_id;
    logic [18:0]        rd_addr;
    logic signed [3:0]  rd_data = '0;
    logic signed [3:0]  pix_data;
    logic               busy, frame_valid;
    logic [15:0]        frame_count;
    int                 n_chk = 0, n_pass = 0;

    render_scheduler #(.NUM_SOLVERS(3), .WIDTH(640), .HEIGHT(8), .CLEAR_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_view_valid(view_valid), .o_view_ready(view_ready),
        .i_view_min_x(view_min_x), .i_view_min_y(view_min_y),
        .i_view_dx(view_dx), .i_view_dy(view_dy),
        .o_min_x(min_x), .o_min_y(min_y), .o_max_x(max_x), .o_max_y(max_y),
        .o_dx(dx), .o_dy(dy),
        .o_solver_reset(solver_reset), .i_solver_done(solver_done),
        .i_scan_sof(scan_sof), .i_scan_advance(scan_advance),
        .o_rd_solver_id(rd_solver_id), .o_rd_addr(rd_addr),
        .i_rd_data(rd_data), .o_pix_data(pix_data),
        .o_busy(busy), .o_frame_valid(frame_valid), .o_frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int mx, input int my, input int sx, input int sy);
        view_min_x = 27'(mx);
        view_min_y = 27'(my);
        view_dx    = 27'(sx);
        view_dy    = 27'(sy);
        view_valid = 1'b1;
        tick();
        view_valid = 1'b0;
    endtask

    int exp_id[8]   = '{0, 1, 2, 0, 1, 2, 0, 1};
    int exp_addr[8] = '{0, 0, 0, 1, 1, 1, 2, 2};

    initial begin
        #2;
        chk("rst_solver_reset", solver_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_min_x", min_x, 0);
        chk("rst_rd_addr", rd_addr, 0);
        tick(2);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", view_ready, 1);
        chk("idle_solver_reset", solver_reset, 1);
        chk("idle_max_x", max_x, 0);

        send(-33554432, 100, 4, -3);
        chk("load_busy", busy, 1);
        chk("load_ready", view_ready, 0);
        chk("load_solver_reset", solver_reset, 1);
        chk("load_min_x", min_x, -33554432);
        tick();
        chk("clr1_max_x", max_x, -33551876);
        chk("clr1_max_y", max_y, 79);
        chk("clr1_solver_reset", solver_reset, 1);
        tick();
        chk("clr2_solver_reset", solver_reset, 1);
        tick();
        chk("settle_solver_reset", solver_reset, 0);
        chk("settle_ready", view_ready, 0);
        tick();
        chk("run_ready", view_ready, 1);
        chk("run_busy", busy, 1);
        rd_data = -4'sd3;
        tick(49);
        chk("run_frame_valid", frame_valid, 0);
        chk("run_pix_data", pix_data, 0);
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        chk("done_frame_valid", frame_valid, 1);
        chk("done_frame_count", frame_count, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", view_ready, 1);
        chk("done_pix_data", pix_data, -3);

        solver_done = 1'b1;
        send(0, 0, 1, 1);
        chk("held_load_fv", frame_valid, 0);
        tick(3);
        chk("held_settle_busy", busy, 1);
        chk("held_settle_count", frame_count, 1);
        tick();
        chk("held_run_busy", busy, 1);
        tick();
        chk("held_done_count", frame_count, 2);
        chk("held_done_fv", frame_valid, 1);
        solver_done = 1'b0;

        send(5, 6, 1, 1);
        tick(6);
        chk("abort_pre_busy", busy, 1);
        send(7, 8, 2, 2);
        chk("abort_fv", frame_valid, 0);
        chk("abort_count", frame_count, 2);
        chk("abort_reload", view_ready, 0);
        chk("abort_min_x", min_x, 7);
        tick(4);
        view_min_x = 27'sd9;
        view_valid = 1'b1;
        solver_done = 1'b1;
        tick();
        view_valid = 1'b0;
        solver_done = 1'b0;
        chk("coinc_count", frame_count, 2);
        chk("coinc_fv", frame_valid, 0);
        chk("coinc_solver_reset", solver_reset, 1);
        chk("coinc_min_x", min_x, 9);
        tick(5);
        chk("coinc_max_x", max_x, 9 + 2 * 639);
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        chk("final_count", frame_count, 3);

        scan_sof = 1'b1;
        tick();
        scan_sof = 1'b0;
        scan_advance = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("scan_id%0d", i), rd_solver_id, exp_id[i]);
            chk($sformatf("scan_addr%0d", i), rd_addr, exp_addr[i]);
            if (i < 7) tick();
        end
        scan_sof = 1'b1;
        tick();
        scan_sof = 1'b0;
        chk("sof_pri_id", rd_solver_id, 0);
        chk("sof_pri_addr", rd_addr, 0);
        tick(5119);
        chk("last_id", rd_solver_id, 1);
        chk("last_addr", rd_addr, 1706);
        tick();
        chk("wrap_id", rd_solver_id, 0);
        chk("wrap_addr", rd_addr, 0);
        tick();
        scan_advance = 1'b0;
        chk("post_wrap_id", rd_solver_id, 1);

        send(1, 1, 1, 1);
        tick(5);
        chk("areset_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_solver_reset", solver_reset, 1);
        chk("areset_count", frame_count, 0);
        chk("areset_rd_id", rd_solver_id, 0);
        chk("areset_max_x", max_x, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("areset_idle_ready", view_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
